// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared types and default widths for the pipeline stages of the 5-stage core.
//   mem_state_e   : state encoding of the memory-access stage FSM
//   REG_WIDTH_D   : default datapath width
//   REG_SELECT_D  : default register-index width
//   ADDR_WIDTH_D  : default data-memory address width
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_WIDTH_D  = 32;
    localparam int REG_SELECT_D = 5;
    localparam int ADDR_WIDTH_D = 16;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// Single-master data-memory request/acknowledge bus.
//   o_mem_req   : request, held until i_mem_ack
//   o_mem_we    : 1 = store, 0 = load
//   o_mem_addr  : byte/word address (ADDR_WIDTH)
//   o_mem_wdata : store data (REG_WIDTH)
//   i_mem_ack   : access complete this cycle
//   i_mem_rdata : load data, valid together with i_mem_ack
// Modports: master = memory stage, slave = memory / bus model.
// ---------------------------------------------------------------------------
interface mem_stage_if
    import pipe_pkg::*;
#(
    parameter int REG_WIDTH  = REG_WIDTH_D,
    parameter int ADDR_WIDTH = ADDR_WIDTH_D
) ();

    logic                  o_mem_req;
    logic                  o_mem_we;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [REG_WIDTH-1:0]  o_mem_wdata;
    logic                  i_mem_ack;
    logic [REG_WIDTH-1:0]  i_mem_rdata;

    modport master (
        output o_mem_req,
        output o_mem_we,
        output o_mem_addr,
        output o_mem_wdata,
        input  i_mem_ack,
        input  i_mem_rdata
    );

    modport slave (
        input  o_mem_req,
        input  o_mem_we,
        input  o_mem_addr,
        input  o_mem_wdata,
        output i_mem_ack,
        output i_mem_rdata
    );

endinterface

// File: rtl/mem_stage_watchdog.sv
// ---------------------------------------------------------------------------
// mem_watchdog
// Wait-cycle counter with a sticky error flag for the memory stage. Only
// instantiated when MEM_STAGE_TIMEOUT_EN is defined.
//   clk, rst  : clock, asynchronous active-high reset
//   in_wait   : FSM is in MS_WAIT this cycle
//   ack       : bus acknowledge (wins over a timeout in the same cycle)
//   timeout   : this is the TIMEOUT_CYCLES-th wait cycle without ack
//   error     : sticky, set by the first timeout, cleared only by rst
// ---------------------------------------------------------------------------
module mem_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic in_wait,
    input  logic ack,
    output logic timeout,
    output logic error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counter holds the number of wait cycles already completed, so the
    // TIMEOUT_CYCLES-th wait cycle is the one where it equals TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;
    logic             error_reg;

    assign timeout = in_wait & ~ack & (count_reg == LAST_WAIT);
    assign error   = error_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            error_reg <= 1'b0;
        end else begin
            // Any state other than MS_WAIT clears the count, so each access
            // starts from zero when it leaves MS_IDLE.
            if (in_wait) begin
                count_reg <= count_reg + 1'b1;
            end else begin
                count_reg <= '0;
            end
            if (timeout) begin
                error_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory-access stage between pipe_M and pipe_W. Issues loads/stores on the
// data-memory bus and holds o_stall while an access is outstanding.
//   clk, rst           : clock, asynchronous active-high reset
//   i_enable           : pipeline advance; leaves MS_DONE when high
//   i_reg_b            : store data
//   i_alu_data         : ALU result / effective address (low ADDR_WIDTH bits)
//   i_reg_c_select     : destination register
//   i_is_write/load/store : control from pipe_M (load wins over store)
//   o_mem_data         : load data for pipe_W (0 except in MS_DONE)
//   o_alu_data, o_reg_c_select, o_is_write, o_is_load : pass-through
//   o_stall            : access in flight
//   o_mem_error        : sticky timeout flag
//   mem                : data-memory bus (master side)
// Optional: define MEM_STAGE_TIMEOUT_EN to abandon an access after
// TIMEOUT_CYCLES wait cycles and flag o_mem_error.
// ---------------------------------------------------------------------------
module mem_stage
    import pipe_pkg::*;
#(
    parameter int          REG_WIDTH      = REG_WIDTH_D,
    parameter int          REG_SELECT     = REG_SELECT_D,
    parameter int          ADDR_WIDTH     = ADDR_WIDTH_D,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic [REG_WIDTH-1:0]  i_reg_b,
    input  logic [REG_WIDTH-1:0]  i_alu_data,
    input  logic [REG_SELECT-1:0] i_reg_c_select,
    input  logic                  i_is_write,
    input  logic                  i_is_load,
    input  logic                  i_is_store,
    output logic [REG_WIDTH-1:0]  o_mem_data,
    output logic [REG_WIDTH-1:0]  o_alu_data,
    output logic [REG_SELECT-1:0] o_reg_c_select,
    output logic                  o_is_write,
    output logic                  o_is_load,
    output logic                  o_stall,
    output logic                  o_mem_error,
    mem_stage_if.master           mem
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
        $error("mem_stage: TIMEOUT_CYCLES must be at least 1");
    end

    mem_state_e           state_reg;
    mem_state_e           state_next;
    logic [REG_WIDTH-1:0] data_reg;
    logic [REG_WIDTH-1:0] data_next;
    logic                 req_active;
    logic                 mem_op;
    logic                 timeout;

    assign mem_op = i_is_load | i_is_store;

    assign o_alu_data     = i_alu_data;
    assign o_reg_c_select = i_reg_c_select;
    assign o_is_write     = i_is_write;
    assign o_is_load      = i_is_load;

`ifdef MEM_STAGE_TIMEOUT_EN
    mem_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .in_wait (state_reg == MS_WAIT),
        .ack     (mem.i_mem_ack),
        .timeout (timeout),
        .error   (o_mem_error)
    );
`else
    assign timeout     = 1'b0;
    assign o_mem_error = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= MS_IDLE;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        req_active = 1'b0;
        case (state_reg)
            MS_IDLE: begin
                if (mem_op) begin
                    req_active = 1'b1;
                    if (mem.i_mem_ack) begin
                        data_next  = i_is_load ? mem.i_mem_rdata : '0;
                        state_next = MS_DONE;
                    end else begin
                        state_next = MS_WAIT;
                    end
                end
            end
            MS_WAIT: begin
                // Upstream is frozen, so the request fields stay stable
                // without being registered here.
                req_active = 1'b1;
                if (mem.i_mem_ack) begin
                    data_next  = i_is_load ? mem.i_mem_rdata : '0;
                    state_next = MS_DONE;
                end else if (timeout) begin
                    data_next  = '0;
                    state_next = MS_DONE;
                end
            end
            MS_DONE: begin
                if (i_enable) begin
                    state_next = MS_IDLE;
                end
            end
            default: begin
                state_next = MS_IDLE;
            end
        endcase
    end

    // Gating with rst drops the request the instant reset is asserted rather
    // than at the next clock, so a mid-access reset abandons the bus at once.
    always_comb begin
        o_stall         = req_active & ~rst;
        mem.o_mem_req   = req_active & ~rst;
        mem.o_mem_we    = req_active & ~rst & i_is_store & ~i_is_load;
        mem.o_mem_addr  = (req_active & ~rst) ? i_alu_data[ADDR_WIDTH-1:0] : '0;
        mem.o_mem_wdata = (req_active & ~rst & i_is_store & ~i_is_load) ? i_reg_b : '0;
        o_mem_data      = (state_reg == MS_DONE) ? data_reg : '0;
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import pipe_pkg::*;

    localparam int RW  = 32;
    localparam int RS  = 5;
    localparam int AW  = 16;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_enable;
    logic [RW-1:0] i_reg_b;
    logic [RW-1:0] i_alu_data;
    logic [RS-1:0] i_reg_c_select;
    logic          i_is_write;
    logic          i_is_load;
    logic          i_is_store;
    logic [RW-1:0] o_mem_data;
    logic [RW-1:0] o_alu_data;
    logic [RS-1:0] o_reg_c_select;
    logic          o_is_write;
    logic          o_is_load;
    logic          o_stall;
    logic          o_mem_error;

    int total = 0;
    int bad   = 0;
    logic [RW-1:0] exp_q[$];

    always #5 clk = ~clk;

    mem_stage_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();

    mem_stage #(
        .REG_WIDTH      (RW),
        .REG_SELECT     (RS),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_enable       (i_enable),
        .i_reg_b        (i_reg_b),
        .i_alu_data     (i_alu_data),
        .i_reg_c_select (i_reg_c_select),
        .i_is_write     (i_is_write),
        .i_is_load      (i_is_load),
        .i_is_store     (i_is_store),
        .o_mem_data     (o_mem_data),
        .o_alu_data     (o_alu_data),
        .o_reg_c_select (o_reg_c_select),
        .o_is_write     (o_is_write),
        .o_is_load      (o_is_load),
        .o_stall        (o_stall),
        .o_mem_error    (o_mem_error),
        .mem            (bus.master)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_enable       = 1'b0;
        i_reg_b        = '0;
        i_alu_data     = '0;
        i_reg_c_select = '0;
        i_is_write     = 1'b0;
        i_is_load      = 1'b0;
        i_is_store     = 1'b0;
    endtask

    // Drives one load/store, follows it through the stall cycles and MS_DONE,
    // optionally holding MS_DONE for 'hold' cycles with a stray ack present.
    // ack_delay < 0 means the bus never acknowledges.
    task automatic run_access(input string name, input logic ld, input logic st,
                              input logic [AW-1:0] addr, input logic [RW-1:0] wd,
                              input int ack_delay, input logic [RW-1:0] rd, input int hold);
        logic [RW-1:0] exp_data;
        logic [RW-1:0] exp_wdata;
        logic          exp_we;
        int            stalls;
        int            exp_stalls;
        bit            done;
        exp_data   = ld ? rd : '0;
        exp_we     = st & ~ld;
        exp_wdata  = exp_we ? wd : '0;
        exp_stalls = (ack_delay >= 0) ? ack_delay + 1 : TMO + 1;
        exp_q.push_back(exp_data);
        i_enable       = 1'b0;
        i_is_load      = ld;
        i_is_store     = st;
        i_is_write     = ld;
        i_alu_data     = {16'hA5C3, addr};
        i_reg_b        = wd;
        i_reg_c_select = 5'd7;
        bus.i_mem_ack   = (ack_delay == 0);
        bus.i_mem_rdata = (ack_delay == 0) ? rd : 32'h0BAD_0BAD;
        stalls = 0;
        done   = 0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            #1;
            if (!o_stall) begin
                done = 1;
                break;
            end
            stalls++;
            total++;
            if (bus.o_mem_req !== 1'b1 || bus.o_mem_we !== exp_we ||
                bus.o_mem_addr !== addr || bus.o_mem_wdata !== exp_wdata) begin
                bad++;
                $display("FAIL %s_bus cyc=%0d got req=%b we=%b addr=%h wdata=%h expected req=1 we=%b addr=%h wdata=%h",
                         name, cyc, bus.o_mem_req, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata,
                         exp_we, addr, exp_wdata);
            end
            step();
            bus.i_mem_ack   = (stalls == ack_delay);
            bus.i_mem_rdata = (stalls == ack_delay) ? rd : 32'h0BAD_0BAD;
        end
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = '0;
        total++;
        if (!done || stalls !== exp_stalls) begin
            bad++;
            $display("FAIL %s_stalls got %0d (finished=%0d) expected %0d", name, stalls, done, exp_stalls);
        end
        exp_data = exp_q.pop_front();
        total++;
        if (o_mem_data !== exp_data || bus.o_mem_req !== 1'b0 || o_is_load !== ld) begin
            bad++;
            $display("FAIL %s_done got data=%h req=%b is_load=%b expected data=%h req=0 is_load=%b",
                     name, o_mem_data, bus.o_mem_req, o_is_load, exp_data, ld);
        end
        for (int h = 0; h < hold; h++) begin
            bus.i_mem_ack   = 1'b1;
            bus.i_mem_rdata = 32'h5555_AAAA;
            step();
            total++;
            if (o_mem_data !== exp_data || bus.o_mem_req !== 1'b0 || o_stall !== 1'b0) begin
                bad++;
                $display("FAIL %s_hold%0d got data=%h req=%b stall=%b expected data=%h req=0 stall=0",
                         name, h, o_mem_data, bus.o_mem_req, o_stall, exp_data);
            end
        end
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = '0;
        i_enable = 1'b1;
        step();
        clear_inputs();
        #1;
        total++;
        if (o_mem_data !== '0 || bus.o_mem_req !== 1'b0 || o_stall !== 1'b0 || bus.o_mem_addr !== '0) begin
            bad++;
            $display("FAIL %s_advance got data=%h req=%b stall=%b addr=%h expected all 0",
                     name, o_mem_data, bus.o_mem_req, o_stall, bus.o_mem_addr);
        end
        $display("txn %s ld=%b st=%b addr=%h wdata=%h ack_delay=%0d stalls=%0d data=%h",
                 name, ld, st, addr, wd, ack_delay, stalls, exp_data);
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (o_stall !== 1'b0 || bus.o_mem_req !== 1'b0 || o_mem_data !== '0 ||
            bus.o_mem_addr !== '0 || bus.o_mem_wdata !== '0 || bus.o_mem_we !== 1'b0 || o_mem_error !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got stall=%b req=%b data=%h addr=%h wdata=%h we=%b err=%b expected all 0",
                     o_stall, bus.o_mem_req, o_mem_data, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_we, o_mem_error);
        end
        rst = 1'b0;
        step();
        total++;
        if (o_stall !== 1'b0 || bus.o_mem_req !== 1'b0 || o_mem_data !== '0) begin
            bad++;
            $display("FAIL reset_release got stall=%b req=%b data=%h expected 0", o_stall, bus.o_mem_req, o_mem_data);
        end
        $display("txn reset");
    endtask

    task automatic test_alu_op();
        i_is_write = 1'b1;
        i_alu_data = 32'h0000_1234;
        i_reg_c_select = 5'd9;
        i_enable = 1'b1;
        #1;
        total++;
        if (o_stall !== 1'b0 || bus.o_mem_req !== 1'b0 || o_alu_data !== 32'h0000_1234 ||
            o_mem_data !== '0 || o_reg_c_select !== 5'd9 || o_is_write !== 1'b1 || bus.o_mem_addr !== '0) begin
            bad++;
            $display("FAIL alu_op got stall=%b req=%b alu=%h data=%h rc=%0d wr=%b addr=%h expected 0 0 00001234 0 9 1 0",
                     o_stall, bus.o_mem_req, o_alu_data, o_mem_data, o_reg_c_select, o_is_write, bus.o_mem_addr);
        end
        step();
        // Non-memory op with a stray ack: must be ignored.
        i_is_write = 1'b0;
        i_alu_data = 32'hFFFF_0000;
        bus.i_mem_ack = 1'b1;
        bus.i_mem_rdata = 32'h7777_7777;
        #1;
        total++;
        if (bus.o_mem_req !== 1'b0 || o_stall !== 1'b0 || o_alu_data !== 32'hFFFF_0000) begin
            bad++;
            $display("FAIL alu_stray_ack got req=%b stall=%b alu=%h expected 0 0 ffff0000",
                     bus.o_mem_req, o_stall, o_alu_data);
        end
        step();
        total++;
        if (o_mem_data !== '0 || o_stall !== 1'b0) begin
            bad++;
            $display("FAIL alu_after_ack got data=%h stall=%b expected 0 0", o_mem_data, o_stall);
        end
        bus.i_mem_ack = 1'b0;
        bus.i_mem_rdata = '0;
        clear_inputs();
        $display("txn alu_op alu=00001234");
        step();
    endtask

    task automatic test_load_fast();
        run_access("load_fast", 1'b1, 1'b0, 16'h0040, 32'h0, 0, 32'hDEAD_BEEF, 0);
    endtask

    task automatic test_store_wait();
        run_access("store_wait", 1'b0, 1'b1, 16'h0100, 32'hCAFE_0001, 3, 32'h0, 0);
    endtask

    task automatic test_done_hold();
        run_access("done_hold", 1'b1, 1'b0, 16'h0080, 32'h0, 1, 32'h1357_9BDF, 2);
    endtask

    task automatic test_load_and_store();
        run_access("ld_and_st", 1'b1, 1'b1, 16'h0200, 32'h1111_2222, 1, 32'h3333_4444, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            logic          ld;
            logic [AW-1:0] a;
            logic [RW-1:0] d;
            ld = i[0];
            a  = AW'($urandom_range(0, 16'hFFFF));
            d  = $urandom;
            run_access("b2b", ld, ~ld, a, d, $urandom_range(0, 3), ~d, 0);
        end
    endtask

    task automatic test_reset_mid();
        i_is_load  = 1'b1;
        i_alu_data = 32'h0000_0500;
        step();
        step();
        // Two cycles into MS_WAIT now.
        rst = 1'b1;
        #1;
        total++;
        if (bus.o_mem_req !== 1'b0 || o_stall !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_drop got req=%b stall=%b expected 0 0", bus.o_mem_req, o_stall);
        end
        clear_inputs();
        bus.i_mem_ack = 1'b1;
        bus.i_mem_rdata = 32'h9999_8888;
        step();
        rst = 1'b0;
        step();
        total++;
        if (bus.o_mem_req !== 1'b0 || o_stall !== 1'b0 || o_mem_data !== '0 || bus.o_mem_addr !== '0) begin
            bad++;
            $display("FAIL rst_mid_late_ack got req=%b stall=%b data=%h addr=%h expected all 0",
                     bus.o_mem_req, o_stall, o_mem_data, bus.o_mem_addr);
        end
        bus.i_mem_ack = 1'b0;
        bus.i_mem_rdata = '0;
        $display("txn reset_mid_access");
        step();
        run_access("after_rst", 1'b1, 1'b0, 16'h0044, 32'h0, 0, 32'h2468_ACE0, 0);
    endtask

    task automatic test_timeout();
`ifdef MEM_STAGE_TIMEOUT_EN
        run_access("timeout", 1'b1, 1'b0, 16'h0300, 32'h0, -1, 32'h0, 0);
        total++;
        if (o_mem_error !== 1'b1) begin
            bad++;
            $display("FAIL timeout_error got %b expected 1", o_mem_error);
        end
        run_access("post_timeout", 1'b0, 1'b1, 16'h0304, 32'h0F0F_0F0F, 1, 32'h0, 0);
        total++;
        if (o_mem_error !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky got %b expected 1", o_mem_error);
        end
`else
        total++;
        if (o_mem_error !== 1'b0) begin
            bad++;
            $display("FAIL error_tied got %b expected 0", o_mem_error);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit reached without finishing");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_alu_op();
        test_load_fast();
        test_store_wait();
        test_done_hold();
        test_load_and_store();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage between pipe_M and pipe_W of the 5-stage core.
- Consumes pipe_M outputs and drives a single-master data-memory req/ack bus for loads and stores.
- Produces the pipe_W inputs.
- Asserts o_stall while an access is outstanding, so the hazard logic can freeze D/A/M and hold W.

Parameters:
- REG_WIDTH, 32, datapath width.
- REG_SELECT, 5, register-index width.
- ADDR_WIDTH, 16, memory address width; the address is i_alu_data[ADDR_WIDTH-1:0].
- TIMEOUT_CYCLES, 255, WAIT-cycle limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- i_enable  in  1  global pipeline advance; pipe_W captures on this cycle when high.
- i_reg_b  in  REG_WIDTH  store data.
- i_alu_data  in  REG_WIDTH  ALU result / effective address.
- i_reg_c_select  in  REG_SELECT  destination register.
- i_is_write, i_is_load, i_is_store  in  1 each  control from pipe_M.
- o_mem_data  out  REG_WIDTH  load data to pipe_W.
- o_alu_data  out  REG_WIDTH  = i_alu_data.
- o_reg_c_select  out  REG_SELECT  = i_reg_c_select.
- o_is_write, o_is_load  out  1  = inputs.
- o_stall  out  1  access in flight; the pipeline must not advance.
- o_mem_req  out  1  bus request.
- o_mem_we  out  1  1 = store.
- o_mem_addr  out  ADDR_WIDTH  bus address.
- o_mem_wdata  out  REG_WIDTH  bus write data.
- i_mem_ack  in  1  bus completion.
- i_mem_rdata  in  REG_WIDTH  bus read data, valid with ack.
- o_mem_error  out  1  sticky timeout flag.

Behaviour:
- Reset: one clock, clk; async active-high rst. FSM to MS_IDLE, data register to 0, o_mem_error to 0, timeout counter to 0.
  - All combinational outputs are then 0 whenever the i_* inputs are 0.
- Pass-through: o_alu_data, o_reg_c_select, o_is_write and o_is_load are combinational copies of the inputs in every state.
- mem_op = i_is_load | i_is_store. When both are high, the op is treated as a load (o_mem_we=0).
- MS_IDLE:
  - If mem_op: o_mem_req=1, o_stall=1, with o_mem_addr, o_mem_we and o_mem_wdata driven from the inputs.
  - On i_mem_ack in the same cycle: the data register captures i_mem_rdata (load) or 0 (store); go to MS_DONE.
  - Otherwise go to MS_WAIT.
  - If no mem_op: o_mem_req=0, o_stall=0, stay.
- MS_WAIT:
  - o_mem_req=1 and o_stall=1; address, we and wdata stay stable, because upstream is frozen.
  - On ack: capture as above and go to MS_DONE.
- MS_DONE:
  - o_mem_req=0, o_stall=0, o_mem_data = data register.
  - If i_enable: go to MS_IDLE; pipe_W captures and pipe_M loads the next instruction on the same edge.
  - Otherwise hold MS_DONE with no re-request.
- Minimum memory-op latency: one stall cycle (ack in MS_IDLE) followed by the MS_DONE cycle.
- Non-memory ops: zero stall; o_mem_data = 0.
- i_mem_ack while o_mem_req=0 is ignored.
- o_mem_wdata = i_reg_b for stores, 0 otherwise.
- o_mem_addr = 0 when no request is active.
- rst mid-access: o_mem_req drops asynchronously; the access is abandoned and any late ack is ignored.

Optional Feature:
- Macro MEM_STAGE_TIMEOUT_EN.
- When defined:
  - A counter increments each MS_WAIT cycle and clears on entry to MS_IDLE.
  - When it reaches TIMEOUT_CYCLES without ack: go to MS_DONE with data register 0, set o_mem_error=1.
  - o_mem_error stays set until rst.
- When undefined: MS_WAIT waits indefinitely, o_mem_error is tied to 0, and no counter logic is present.

Decomposition:
- Shared package pipe_pkg: typedef enum logic [1:0] mem_state_e {MS_IDLE, MS_WAIT, MS_DONE}.
- The same package holds the default width constants REG_WIDTH_D=32, REG_SELECT_D=5 and ADDR_WIDTH_D=16.
- The natural sub-module is mem_watchdog (counter plus sticky error), instantiated only under MEM_STAGE_TIMEOUT_EN.

Test Plan:
- ALU op (is_write=1, alu_data=0x1234, no load/store), i_enable=1 -> o_stall=0, o_mem_req=0, o_alu_data=0x1234, o_mem_data=0 in the same cycle.
- Load at 0x0040 with ack in the first cycle, rdata=0xDEADBEEF -> o_stall for 1 cycle, then MS_DONE with o_mem_data=0xDEADBEEF, then MS_IDLE.
- Store 0xCAFE0001 to 0x0100, ack after 3 wait cycles -> o_mem_req=1, o_mem_we=1, addr=0x0100 and wdata stable for 4 cycles, o_stall=1 for 4 cycles, o_mem_data=0.
- Load completes with i_enable=0 for 2 cycles in MS_DONE -> stays in MS_DONE with o_mem_data held and no new o_mem_req; advances on i_enable=1.
- rst pulsed 2 cycles into MS_WAIT, then ack arrives -> o_mem_req=0 immediately, FSM in MS_IDLE, ack ignored, outputs 0.
- With MEM_STAGE_TIMEOUT_EN and TIMEOUT_CYCLES=4, load with no ack -> MS_DONE after 4 wait cycles, o_mem_data=0, o_mem_error=1 and staying 1 through later ops.
